// File: rtl/pim_matmul_engine_pkg.sv
// Shared types and default sizing for the PIM matrix-multiply engine.
package pim_matmul_engine_pkg;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned MATRIX_SIZE = 2;
    localparam int unsigned NUM_PIMS    = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_state_t;

endpackage

// File: rtl/pim_mac_unit.sv
// One multiply-accumulate lane: WIDTH-bit accumulator, modulo 2^WIDTH.
module pim_mac_unit #(
    parameter int unsigned WIDTH = pim_matmul_engine_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_out
);

    logic [WIDTH-1:0] acc_q, acc_d;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + a * b;
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;

endmodule

// File: rtl/pim_matmul_engine.sv
// Fixed-size C = A*B engine: latches operands on start, computes with
// NUM_PIMS MAC lanes in batches of N cycles, then pulses result_ready.
module pim_matmul_engine #(
    parameter int unsigned WIDTH       = pim_matmul_engine_pkg::WIDTH,
    parameter int unsigned MATRIX_SIZE = pim_matmul_engine_pkg::MATRIX_SIZE,
    parameter int unsigned NUM_PIMS    = pim_matmul_engine_pkg::NUM_PIMS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] matrix_A,
    input  logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] matrix_B,
    output logic [WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] result,
    output logic                                     result_ready,
    output logic                                     busy
);

    import pim_matmul_engine_pkg::*;

    localparam int unsigned N  = MATRIX_SIZE;
    localparam int unsigned NE = N * N;
    localparam int unsigned NB = (NE + NUM_PIMS - 1) / NUM_PIMS;
    localparam int unsigned KW = $clog2(N) + 1;
    localparam int unsigned BW = $clog2(NB) + 1;
    localparam int unsigned VW = WIDTH * NE;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

    pim_state_t state_q, state_d;

    logic [KW-1:0] k_q, k_d;
    logic [BW-1:0] bat_q, bat_d;
    logic [VW-1:0] opa_q, opa_d;
    logic [VW-1:0] opb_q, opb_d;
    logic [VW-1:0] res_q, res_d;

    logic batch_end;
    logic run_end;
    logic lane_clr;

    logic [31:0]      lane_e   [NUM_PIMS];
    logic             lane_act [NUM_PIMS];
    logic             lane_en  [NUM_PIMS];
    logic [WIDTH-1:0] lane_a   [NUM_PIMS];
    logic [WIDTH-1:0] lane_b   [NUM_PIMS];
    logic [WIDTH-1:0] lane_acc [NUM_PIMS];

    // Lane decode: element index, activity and operand selection for step k.
    always_comb begin
        batch_end = (state_q == COMPUTE) && (k_q == K_LAST);
        run_end   = batch_end && (bat_q == B_LAST);
        // Accumulators are held clear outside COMPUTE and wiped after each batch.
        lane_clr  = (state_q != COMPUTE) || (k_q == K_LAST);
        for (int unsigned l = 0; l < NUM_PIMS; l++) begin
            lane_e[l]   = 32'(bat_q) * NUM_PIMS + l;
            lane_act[l] = lane_e[l] < NE;
            lane_en[l]  = (state_q == COMPUTE) && lane_act[l];
            lane_a[l]   = '0;
            lane_b[l]   = '0;
            if (lane_act[l]) begin
                lane_a[l] = opa_q[((lane_e[l] / N) * N + 32'(k_q)) * WIDTH +: WIDTH];
                lane_b[l] = opb_q[(32'(k_q) * N + lane_e[l] % N) * WIDTH +: WIDTH];
            end
        end
    end

    // Lane instances, one accumulator per parallel MAC.
    for (genvar g = 0; g < NUM_PIMS; g++) begin : g_lane
        pim_mac_unit #(.WIDTH(WIDTH)) u_mac (
            .clk     (clk),
            .rst     (rst),
            .clr     (lane_clr),
            .en      (lane_en[g]),
            .a       (lane_a[g]),
            .b       (lane_b[g]),
            .acc_out (lane_acc[g])
        );
    end

    // Datapath next values: operand latch, k/batch counters, result writes.
    always_comb begin
        k_d   = k_q;
        bat_d = bat_q;
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        if (state_q == IDLE) begin
            if (start) begin
                opa_d = matrix_A;
                opb_d = matrix_B;
                k_d   = '0;
                bat_d = '0;
            end
        end else if (state_q == COMPUTE) begin
            if (batch_end) begin
                k_d   = '0;
                bat_d = run_end ? '0 : bat_q + 1'b1;
                // The final product term is folded in here rather than waiting
                // a cycle for the accumulator register to absorb it.
                for (int unsigned l = 0; l < NUM_PIMS; l++) begin
                    if (lane_act[l]) begin
                        res_d[lane_e[l] * WIDTH +: WIDTH] = lane_acc[l] + lane_a[l] * lane_b[l];
                    end
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q   <= '0;
            bat_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
        end else begin
            k_q   <= k_d;
            bat_q <= bat_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: if (run_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy         = (state_q != IDLE);
        result_ready = (state_q == DONE);
    end

    assign result = res_q;

endmodule

// File: doc/pim_matmul_engine.md
# pim_matmul_engine

Fixed-size matrix-multiply engine behind the memory block's `pim_ctl` port map (start, matrix_A, matrix_B, result, result_ready). It latches two row-major MATRIX_SIZE×MATRIX_SIZE operand arrays on `start` and computes C = A·B with NUM_PIMS parallel multiply-accumulate lanes. It then presents the result array, held stable, with a one-cycle `result_ready` pulse. The memory block's COMPUTE state waits on that pulse, and its WRITE_RESULT state reads `result` in the following cycle.

## Interface
- WIDTH, default types::WIDTH: element width, unsigned.
- MATRIX_SIZE, default types::MATRIX_SIZE: N, the matrix dimension; N ≥ 1.
- NUM_PIMS, default types::NUM_PIMS (1): number of parallel MAC lanes; 1 ≤ NUM_PIMS ≤ N².
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
- start  in  1  request; sampled only in IDLE.
- matrix_A  in  WIDTH × N²  operand A, row-major: A[i*N+k].
- matrix_B  in  WIDTH × N²  operand B, row-major: B[k*N+j].
- result  out  WIDTH × N²  product C, row-major: C[i*N+j]; registered.
- result_ready  out  1  one-cycle pulse, issued when `result` is complete.
- busy  out  1  high in COMPUTE and DONE.

## Operation
- States (types::pim_state_t):
  - IDLE:
    - If start=1, latch matrix_A and matrix_B into internal operand registers.
    - Clear the accumulators and go to COMPUTE.
  - COMPUTE:
    - Output elements are processed in batches. Batch b covers element indices b*NUM_PIMS + lane.
    - The number of batches is NB = ceil(N²/NUM_PIMS).
    - Each batch takes N cycles; k steps 0..N-1.
    - Each cycle, lane l with element e = i*N+j < N² does acc_l += A[i*N+k]·B[k*N+j].
    - Lanes with e ≥ N² are idle and write nothing.
    - On k = N-1, each active lane writes acc + product into result[e] and clears its accumulator.
    - After the last batch, go to DONE.
  - DONE: result_ready=1 for this cycle only, then go to IDLE unconditionally.
- Arithmetic:
  - Unsigned WIDTH×WIDTH product, truncated to WIDTH bits.
  - Accumulation is modulo 2^WIDTH; there is no saturation and no overflow flag.
- `result`:
  - Changes only during COMPUTE, at batch completion.
  - Holds its value through DONE, IDLE and any later period until the next run overwrites it.
- Operand inputs are ignored outside the latch cycle, so the memory block may change matrix_A and matrix_B freely after start.
- start outside IDLE (COMPUTE or DONE) is ignored. It is not queued and has no effect on the run in progress.
- Reset (rst=0), including in the middle of a run:
  - Next state is IDLE.
  - result (all elements), result_ready, busy, the accumulators and the k/batch counters are all 0.
  - A partial run is abandoned; no result_ready is issued for it.

## Timing
- t0 is the cycle in which start=1 is sampled in IDLE.
- COMPUTE occupies cycles t0+1 .. t0+N·NB.
- result_ready=1 and busy=1 in cycle t0+N·NB+1; result is valid from that cycle on.
- First cycle after DONE: busy=0 and the engine is back in IDLE, able to accept start.
- Example latencies:
  - N=2, NUM_PIMS=1: NB=4, result_ready at t0+9.
  - N=2, NUM_PIMS=3: NB=2, result_ready at t0+5.
  - N=3, NUM_PIMS=1: NB=9, result_ready at t0+28.
- Counters:
  - k counter, width $clog2(N)+1.
  - Batch counter, width $clog2(NB)+1.
  - Both wrap to 0 on entry to COMPUTE.
- Memory-side handshake: start may be a single-cycle pulse; the one-cycle result_ready pulse is sufficient for the memory block's COMPUTE→WRITE_RESULT transition.

## Structure
- Package types gains:
  - NUM_PIMS, default 1.
  - pim_state_t, a 2-bit enum {IDLE, COMPUTE, DONE}.
- Package types already supplies WIDTH and MATRIX_SIZE.
- Sub-module pim_mac_unit, one instance per lane (generate loop).
  - Ports: clk, rst, clr, en, a, b, acc_out.
  - Registered WIDTH-bit accumulator with the same active-low synchronous reset.
- Top level holds the FSM, counters, operand latches, lane index decode and the result registers.

## Test plan
- Basic product, N=2, NUM_PIMS=1: A=[1,2,3,4], B=[5,6,7,8], 1-cycle start → result=[19,22,43,50]; result_ready for exactly one cycle at t0+9; busy high t0+1..t0+9.
- Identity, N=3, NUM_PIMS=1: A=I, B=[1..9] → result=[1..9]; result_ready at t0+28. Then drive A=B=0 in IDLE without start → result unchanged.
- Uneven lanes, N=2, NUM_PIMS=3: same operands as the basic product → [19,22,43,50] at t0+5. The idle lane in batch 1 must not write result[4..5] or alias any element.
- Wrap-around, WIDTH=8, N=2: A=B all 16 → every element 512 mod 256 = 0. Then A=B all 255, N=2 → every element (2·65025) mod 256 = 2.
- Start while busy: second start at t0+3 with different operands → first result is unchanged, a single result_ready pulse occurs, and no second run starts.
- Reset mid-compute: rst=0 at t0+4 for one cycle → result all 0, result_ready and busy 0 with no pulse. A fresh start afterwards completes normally at t0'+9.
